// File: rtl/mem_arbiter_if.sv
// Bundles both requester ports and the shared memory port of mem_arbiter.
// master is the arbiter's view; slave is the view of the requesters and the memory.
interface mem_arbiter_if #(
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH     = 16
);
    logic [MEM_ADDR_WIDTH-1:0] m0_addr;
    logic [MEM_ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0]     m0_data_in;
    logic [DATA_WIDTH-1:0]     m1_data_in;
    logic                      m0_r_en;
    logic                      m1_r_en;
    logic                      m0_w_en;
    logic                      m1_w_en;
    logic                      m0_rdy;
    logic                      m1_rdy;
    logic                      m0_cplt;
    logic                      m1_cplt;
    logic [DATA_WIDTH-1:0]     m0_data_out;
    logic [DATA_WIDTH-1:0]     m1_data_out;

    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]     mem_data_in;
    logic                      mem_r_en;
    logic                      mem_w_en;
    logic [DATA_WIDTH-1:0]     mem_data_out;
    logic                      mem_rdy;
    logic                      mem_cplt;

    modport master (
        input  m0_addr, m1_addr, m0_data_in, m1_data_in,
        input  m0_r_en, m1_r_en, m0_w_en, m1_w_en,
        output m0_rdy, m1_rdy, m0_cplt, m1_cplt, m0_data_out, m1_data_out,
        output mem_addr, mem_data_in, mem_r_en, mem_w_en,
        input  mem_data_out, mem_rdy, mem_cplt
    );

    modport slave (
        output m0_addr, m1_addr, m0_data_in, m1_data_in,
        output m0_r_en, m1_r_en, m0_w_en, m1_w_en,
        input  m0_rdy, m1_rdy, m0_cplt, m1_cplt, m0_data_out, m1_data_out,
        input  mem_addr, mem_data_in, mem_r_en, mem_w_en,
        output mem_data_out, mem_rdy, mem_cplt
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: one-entry request slot per requester, round-robin on ties,
// at most one memory transaction in flight (IDLE -> ISSUE -> WAIT -> IDLE).
module mem_arbiter #(
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH     = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [1:0]                slot_valid_q, slot_valid_d;
    logic [1:0]                slot_write_q, slot_write_d;
    logic [MEM_ADDR_WIDTH-1:0] slot_addr_q [2];
    logic [MEM_ADDR_WIDTH-1:0] slot_addr_d [2];
    logic [DATA_WIDTH-1:0]     slot_data_q [2];
    logic [DATA_WIDTH-1:0]     slot_data_d [2];
    logic                      grant_q, grant_d;
    logic                      last_grant_q, last_grant_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]     mem_data_in_q, mem_data_in_d;
    logic                      mem_r_en_q, mem_r_en_d;
    logic                      mem_w_en_q, mem_w_en_d;
    logic [1:0]                cplt_q, cplt_d;
    logic [DATA_WIDTH-1:0]     data_out_q [2];
    logic [DATA_WIDTH-1:0]     data_out_d [2];

    logic [1:0]                req_r;
    logic [1:0]                req_w;
    logic [MEM_ADDR_WIDTH-1:0] req_addr [2];
    logic [DATA_WIDTH-1:0]     req_data [2];
    logic [1:0]                accept;
    logic                      pick;

    assign req_r       = {bus.m1_r_en, bus.m0_r_en};
    assign req_w       = {bus.m1_w_en, bus.m0_w_en};
    assign req_addr[0] = bus.m0_addr;
    assign req_addr[1] = bus.m1_addr;
    assign req_data[0] = bus.m0_data_in;
    assign req_data[1] = bus.m1_data_in;

    // A slot only takes a request while empty, so rdy never depends on the strobes.
    assign accept = (req_r | req_w) & ~slot_valid_q;

    // On a tie the requester that did not win last time goes next.
    assign pick = (&slot_valid_q) ? ~last_grant_q : slot_valid_q[1];

    always_comb begin
        state_d       = state_q;
        slot_valid_d  = slot_valid_q;
        slot_write_d  = slot_write_q;
        slot_addr_d   = slot_addr_q;
        slot_data_d   = slot_data_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        mem_addr_d    = mem_addr_q;
        mem_data_in_d = mem_data_in_q;
        mem_r_en_d    = 1'b0;
        mem_w_en_d    = 1'b0;
        cplt_d        = 2'b00;
        data_out_d    = data_out_q;

        for (int i = 0; i < 2; i++) begin
            if (accept[i]) begin
                slot_valid_d[i] = 1'b1;
                slot_write_d[i] = req_w[i];
                slot_addr_d[i]  = req_addr[i];
                slot_data_d[i]  = req_data[i];
            end
        end

        case (state_q)
            IDLE: begin
                if ((|slot_valid_q) && bus.mem_rdy) begin
                    state_d       = ISSUE;
                    grant_d       = pick;
                    mem_addr_d    = slot_addr_q[pick];
                    mem_data_in_d = slot_data_q[pick];
                    mem_r_en_d    = ~slot_write_q[pick];
                    mem_w_en_d    = slot_write_q[pick];
                end
            end
            ISSUE, WAIT: begin
                if (bus.mem_cplt) begin
                    state_d               = IDLE;
                    slot_valid_d[grant_q] = 1'b0;
                    cplt_d[grant_q]       = 1'b1;
                    last_grant_d          = grant_q;
                    if (!slot_write_q[grant_q]) begin
                        data_out_d[grant_q] = bus.mem_data_out;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            slot_valid_q  <= 2'b00;
            slot_write_q  <= 2'b00;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            mem_addr_q    <= '0;
            mem_data_in_q <= '0;
            mem_r_en_q    <= 1'b0;
            mem_w_en_q    <= 1'b0;
            cplt_q        <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                slot_addr_q[i] <= '0;
                slot_data_q[i] <= '0;
                data_out_q[i]  <= '0;
            end
        end else begin
            state_q       <= state_d;
            slot_valid_q  <= slot_valid_d;
            slot_write_q  <= slot_write_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_in_q <= mem_data_in_d;
            mem_r_en_q    <= mem_r_en_d;
            mem_w_en_q    <= mem_w_en_d;
            cplt_q        <= cplt_d;
            for (int i = 0; i < 2; i++) begin
                slot_addr_q[i] <= slot_addr_d[i];
                slot_data_q[i] <= slot_data_d[i];
                data_out_q[i]  <= data_out_d[i];
            end
        end
    end

    assign bus.m0_rdy      = ~slot_valid_q[0];
    assign bus.m1_rdy      = ~slot_valid_q[1];
    assign bus.m0_cplt     = cplt_q[0];
    assign bus.m1_cplt     = cplt_q[1];
    assign bus.m0_data_out = data_out_q[0];
    assign bus.m1_data_out = data_out_q[1];
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_data_in = mem_data_in_q;
    assign bus.mem_r_en    = mem_r_en_q;
    assign bus.mem_w_en    = mem_w_en_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model checked every cycle, a simple memory
// responder, and directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int check_count = 0;
    int error_count = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Memory responder: answers each strobe mem_latency cycles later; reads return a fixed pattern.
    int          mem_latency = 1;
    bit          resp_enable = 1'b1;
    int          inject_req  = 0;
    int          inject_ack  = 0;
    int          countdown   = -1;
    bit          pend_rd;
    logic [7:0]  pend_addr;
    logic [15:0] wr_log [256];

    function automatic logic [15:0] read_value(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {a, ~a};
    endfunction

    always @(negedge clk) begin
        bus.mem_cplt = 1'b0;
        if (!rst) begin
            countdown = -1;
        end else begin
            if (bus.mem_r_en || bus.mem_w_en) begin
                if (bus.mem_w_en) wr_log[bus.mem_addr[7:0]] = bus.mem_data_in;
                pend_rd   = bus.mem_r_en && !bus.mem_w_en;
                pend_addr = bus.mem_addr[7:0];
                countdown = resp_enable ? mem_latency : -1;
            end else if (countdown > 0) begin
                countdown--;
            end
            if (countdown == 0) begin
                bus.mem_cplt     = 1'b1;
                bus.mem_data_out = pend_rd ? read_value(pend_addr) : 16'h0000;
                countdown        = -1;
            end
        end
        if (inject_req != inject_ack) begin
            bus.mem_cplt = 1'b1;
            inject_ack   = inject_req;
        end
    end

    // Completion monitor: counts pulses and records which requester finished, in order.
    int cplt_cnt [2] = '{0, 0};
    int cplt_order [$];

    always @(negedge clk) begin
        if (bus.m0_cplt === 1'b1) begin
            cplt_cnt[0]++;
            cplt_order.push_back(0);
        end
        if (bus.m1_cplt === 1'b1) begin
            cplt_cnt[1]++;
            cplt_order.push_back(1);
        end
    end

    // Transaction-level model: a pending request per requester and one busy memory port.
    typedef struct {
        bit          v;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
    } slot_t;

    slot_t       pend [2];
    bit          busy;
    int          owner;
    int          last_owner;
    bit          exp_cplt [2];
    logic [15:0] exp_dout [2];
    bit          exp_ren;
    bit          exp_wen;
    logic [15:0] exp_maddr;
    logic [15:0] exp_mdata;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            pend[i]     = '{v: 1'b0, wr: 1'b0, addr: 16'h0, data: 16'h0};
            exp_cplt[i] = 1'b0;
            exp_dout[i] = 16'h0;
        end
        busy       = 1'b0;
        owner      = 0;
        last_owner = 1;
        exp_ren    = 1'b0;
        exp_wen    = 1'b0;
        exp_maddr  = 16'h0;
        exp_mdata  = 16'h0;
    endtask

    task automatic model_step();
        bit          acc [2];
        bit          rd [2];
        bit          wr [2];
        logic [15:0] a [2];
        logic [15:0] d [2];
        int          pick;
        rd[0] = bus.m0_r_en; wr[0] = bus.m0_w_en; a[0] = bus.m0_addr; d[0] = bus.m0_data_in;
        rd[1] = bus.m1_r_en; wr[1] = bus.m1_w_en; a[1] = bus.m1_addr; d[1] = bus.m1_data_in;
        for (int i = 0; i < 2; i++) acc[i] = !pend[i].v && (rd[i] || wr[i]);
        exp_cplt[0] = 1'b0;
        exp_cplt[1] = 1'b0;
        exp_ren     = 1'b0;
        exp_wen     = 1'b0;
        if (busy) begin
            if (bus.mem_cplt === 1'b1) begin
                pend[owner].v   = 1'b0;
                exp_cplt[owner] = 1'b1;
                if (!pend[owner].wr) exp_dout[owner] = bus.mem_data_out;
                last_owner = owner;
                busy       = 1'b0;
            end
        end else if (bus.mem_rdy && (pend[0].v || pend[1].v)) begin
            if (pend[0].v && pend[1].v) pick = 1 - last_owner;
            else                        pick = pend[0].v ? 0 : 1;
            busy      = 1'b1;
            owner     = pick;
            exp_maddr = pend[pick].addr;
            exp_mdata = pend[pick].data;
            exp_wen   = pend[pick].wr;
            exp_ren   = !pend[pick].wr;
        end
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) pend[i] = '{v: 1'b1, wr: wr[i], addr: a[i], data: d[i]};
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    always @(negedge clk) begin
        check_output("m0_rdy",      bus.m0_rdy,      !pend[0].v);
        check_output("m1_rdy",      bus.m1_rdy,      !pend[1].v);
        check_output("m0_cplt",     bus.m0_cplt,     exp_cplt[0]);
        check_output("m1_cplt",     bus.m1_cplt,     exp_cplt[1]);
        check_output("m0_data_out", bus.m0_data_out, exp_dout[0]);
        check_output("m1_data_out", bus.m1_data_out, exp_dout[1]);
        check_output("mem_addr",    bus.mem_addr,    exp_maddr);
        check_output("mem_data_in", bus.mem_data_in, exp_mdata);
        check_output("mem_r_en",    bus.mem_r_en,    exp_ren);
        check_output("mem_w_en",    bus.mem_w_en,    exp_wen);
    end

    task automatic drive_req(input int idx, input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] data);
        if (idx == 0) begin
            bus.m0_r_en = rd; bus.m0_w_en = wr; bus.m0_addr = addr; bus.m0_data_in = data;
        end else begin
            bus.m1_r_en = rd; bus.m1_w_en = wr; bus.m1_addr = addr; bus.m1_data_in = data;
        end
    endtask

    task automatic clear_req(input int idx);
        if (idx == 0) begin
            bus.m0_r_en = 1'b0; bus.m0_w_en = 1'b0;
        end else begin
            bus.m1_r_en = 1'b0; bus.m1_w_en = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input int idx, input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] data);
        drive_req(idx, rd, wr, addr, data);
        @(negedge clk);
        clear_req(idx);
    endtask

    task automatic wait_cplt(input int idx, input int target, input int budget, input string name);
        int n = 0;
        while (cplt_cnt[idx] < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(name, cplt_cnt[idx] >= target, 1);
    endtask

    task automatic wait_strobe(input int budget, input string name);
        int n = 0;
        while (!(bus.mem_r_en || bus.mem_w_en) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(name, bus.mem_r_en || bus.mem_w_en, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base0;
        int base1;
        int start;
        int issued;

        bus.m0_r_en = 1'b0; bus.m0_w_en = 1'b0; bus.m0_addr = '0; bus.m0_data_in = '0;
        bus.m1_r_en = 1'b0; bus.m1_w_en = 1'b0; bus.m1_addr = '0; bus.m1_data_in = '0;
        bus.mem_rdy = 1'b1;

        // Reset state
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_m0_rdy",   bus.m0_rdy,   1);
        check_output("reset_m1_rdy",   bus.m1_rdy,   1);
        check_output("reset_mem_addr", bus.mem_addr, 0);
        check_output("reset_mem_r_en", bus.mem_r_en, 0);
        check_output("reset_m0_cplt",  bus.m0_cplt,  0);
        #2 rst = 1'b1;

        // Tie from reset: m0 first, then m1
        mem_latency = 1;
        @(negedge clk);
        drive_req(0, 1'b0, 1'b1, 16'h0001, 16'h1111);
        drive_req(1, 1'b0, 1'b1, 16'h0002, 16'h2222);
        @(negedge clk);
        clear_req(0);
        clear_req(1);
        wait_cplt(1, 1, 40, "tie_m1_done");
        repeat (2) @(negedge clk);
        check_output("tie_first",   cplt_order[0], 0);
        check_output("tie_second",  cplt_order[1], 1);
        check_output("tie_m0_cnt",  cplt_cnt[0],   1);
        check_output("tie_m1_cnt",  cplt_cnt[1],   1);
        check_output("tie_wr_m0",   wr_log[1],     16'h1111);
        check_output("tie_wr_m1",   wr_log[2],     16'h2222);

        // Fairness: both requesters refill on every completion, 8 transactions
        mem_latency = 2;
        start  = cplt_order.size();
        @(negedge clk);
        drive_req(0, 1'b0, 1'b1, 16'h0100, 16'h5000);
        drive_req(1, 1'b0, 1'b1, 16'h0180, 16'h6000);
        issued = 2;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            clear_req(0);
            clear_req(1);
            if (cplt_order.size() - start >= 8) break;
            if (bus.m0_cplt && issued < 8) begin
                drive_req(0, 1'b0, 1'b1, 16'(16'h0100 + issued), 16'(16'h5000 + issued));
                issued++;
            end
            if (bus.m1_cplt && issued < 8) begin
                drive_req(1, 1'b0, 1'b1, 16'(16'h0180 + issued), 16'(16'h6000 + issued));
                issued++;
            end
        end
        check_output("fair_count", cplt_order.size() - start >= 8, 1);
        for (int k = 0; k < 8; k++) begin
            if (start + k < cplt_order.size()) check_output("fair_grant", cplt_order[start + k], k % 2);
        end

        // Single read with 3-cycle memory latency
        mem_latency = 3;
        base0 = cplt_cnt[0];
        base1 = cplt_cnt[1];
        @(negedge clk);
        apply_stimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        wait_cplt(0, base0 + 1, 30, "read_done");
        repeat (3) @(negedge clk);
        check_output("read_data",    bus.m0_data_out, 16'hBEEF);
        check_output("read_m1_data", bus.m1_data_out, 16'h0000);
        check_output("read_pulses",  cplt_cnt[0],     base0 + 1);
        check_output("read_m1_cnt",  cplt_cnt[1],     base1);

        // Minimum latency: completion while in ISSUE
        mem_latency = 0;
        @(negedge clk);
        drive_req(0, 1'b1, 1'b0, 16'h0011, 16'h0000);
        @(negedge clk);
        clear_req(0);
        check_output("lat_e0_cplt", bus.m0_cplt, 0);
        @(negedge clk);
        check_output("lat_e1_ren",  bus.mem_r_en, 1);
        check_output("lat_e1_cplt", bus.m0_cplt,  0);
        @(negedge clk);
        check_output("lat_e2_cplt", bus.m0_cplt,     1);
        check_output("lat_e2_rdy",  bus.m0_rdy,      1);
        check_output("lat_e2_data", bus.m0_data_out, 16'h11EE);
        @(negedge clk);
        check_output("lat_e3_cplt", bus.m0_cplt, 0);

        // Back-pressure: mem_rdy low with both slots full; m0 won last, so m1 goes first
        mem_latency = 1;
        base0 = cplt_cnt[0];
        base1 = cplt_cnt[1];
        @(negedge clk);
        bus.mem_rdy = 1'b0;
        drive_req(0, 1'b0, 1'b1, 16'h0030, 16'h3333);
        drive_req(1, 1'b0, 1'b1, 16'h0031, 16'h4444);
        @(negedge clk);
        clear_req(0);
        clear_req(1);
        for (int k = 0; k < 5; k++) begin
            check_output("bp_no_ren", bus.mem_r_en, 0);
            check_output("bp_no_wen", bus.mem_w_en, 0);
            check_output("bp_m0_rdy", bus.m0_rdy,   0);
            check_output("bp_m1_rdy", bus.m1_rdy,   0);
            if (k < 4) @(negedge clk);
        end
        bus.mem_rdy = 1'b1;
        @(negedge clk);
        check_output("bp_first_wen",  bus.mem_w_en,    1);
        check_output("bp_first_addr", bus.mem_addr,    16'h0031);
        check_output("bp_first_data", bus.mem_data_in, 16'h4444);
        wait_cplt(0, base0 + 1, 40, "bp_m0_done");
        wait_cplt(1, base1 + 1, 40, "bp_m1_done");

        // Reset while m1's read is outstanding
        resp_enable = 1'b0;
        base1 = cplt_cnt[1];
        @(negedge clk);
        apply_stimulus(1, 1'b1, 1'b0, 16'h0040, 16'h0000);
        wait_strobe(20, "rst_issue_seen");
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_output("rst_m1_rdy",   bus.m1_rdy,      1);
        check_output("rst_mem_addr", bus.mem_addr,    0);
        check_output("rst_m0_data",  bus.m0_data_out, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        inject_req++;
        repeat (4) @(negedge clk);
        check_output("rst_no_m1_cplt", cplt_cnt[1],  base1);
        check_output("rst_after_ren",  bus.mem_r_en, 0);
        check_output("rst_after_rdy",  bus.m1_rdy,   1);
        resp_enable = 1'b1;

        // Conflicting strobes are treated as a write
        mem_latency = 1;
        base1 = cplt_cnt[1];
        @(negedge clk);
        apply_stimulus(1, 1'b1, 1'b1, 16'h0050, 16'h00AA);
        wait_strobe(20, "conflict_issue_seen");
        check_output("conflict_wen",  bus.mem_w_en,    1);
        check_output("conflict_ren",  bus.mem_r_en,    0);
        check_output("conflict_data", bus.mem_data_in, 16'h00AA);
        wait_cplt(1, base1 + 1, 20, "conflict_done");
        repeat (2) @(negedge clk);
        check_output("conflict_m1_data", bus.m1_data_out, 16'h0000);
        check_output("conflict_mem",     wr_log[8'h50],   16'h00AA);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
